// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: two combinational read ports, one clocked write port.
// Register 31 is hardwired to zero. Asynchronous active-high reset clears all storage.
module regfile_32x64 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rdAddrA,
    input  logic [ADDR_WIDTH-1:0] rdAddrB,
    output logic [DATA_WIDTH-1:0] rdDataA,
    output logic [DATA_WIDTH-1:0] rdDataB,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  write
);

    localparam int                  NREGS     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '1;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] regs_d [NREGS];
    logic                  wr_en;

    assign wr_en = write && (wrAddr != ZERO_ADDR);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[wrAddr] = wrData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // No write-to-read bypass: reads always see committed state; reg 31 and reset force zero.
    always_comb begin
        rdDataA = '0;
        rdDataB = '0;
        if (!reset && (rdAddrA != ZERO_ADDR)) begin
            rdDataA = regs_q[rdAddrA];
        end
        if (!reset && (rdAddrB != ZERO_ADDR)) begin
            rdDataB = regs_q[rdAddrB];
        end
    end

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64.
module tb_regfile_32x64;

    logic        clk;
    logic        reset;
    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic [63:0] rdDataA;
    logic [63:0] rdDataB;
    logic [4:0]  wrAddr;
    logic [63:0] wrData;
    logic        write;

    int checks   = 0;
    int failures = 0;

    logic [63:0] model [32];

    regfile_32x64 dut (
        .clk     (clk),
        .reset   (reset),
        .rdAddrA (rdAddrA),
        .rdAddrB (rdAddrB),
        .rdDataA (rdDataA),
        .rdDataB (rdDataB),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .write   (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        write  = 1'b1;
        wrAddr = a;
        wrData = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        if (a != 5'd31) model[a] = d;
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b,
                             input logic [63:0] ea, input logic [63:0] eb, input string tag);
        rdAddrA = a;
        rdAddrB = b;
        #1;
        chk({tag, "_A"}, rdDataA, ea);
        chk({tag, "_B"}, rdDataB, eb);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) begin
            rdAddrA = 5'(i);
            rdAddrB = 5'(31 - i);
            #1;
            chk($sformatf("%s_A%0d", tag, i), rdDataA, (i == 31) ? 64'h0 : model[i]);
            chk($sformatf("%s_B%0d", tag, 31 - i), rdDataB, (i == 0) ? 64'h0 : model[31 - i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        reset   = 1'b1;
        write   = 1'b0;
        wrAddr  = 5'd0;
        wrData  = 64'h0;
        rdAddrA = 5'd0;
        rdAddrB = 5'd0;

        // Reset held 100 ns; reads are zero during and after
        #50;
        read_pair(5'd3, 5'd17, 64'h0, 64'h0, "in_reset");
        #49;
        reset = 1'b0;
        check_all("post_reset");

        // Basic writes
        do_write(5'd0, 64'h0000_0000_0000_FFFF);
        do_write(5'd1, 64'h0000_0000_0000_AAAA);
        do_write(5'd2, 64'h0000_0000_0000_CCCC);
        do_write(5'd3, 64'h0000_0000_0000_F0F0);
        read_pair(5'd0, 5'd1, 64'hFFFF, 64'hAAAA, "basic01");
        read_pair(5'd2, 5'd3, 64'hCCCC, 64'hF0F0, "basic23");

        // Write enable low over several edges
        @(negedge clk);
        write  = 1'b0;
        wrAddr = 5'd5;
        wrData = 64'hDEAD_BEEF_0123_4567;
        repeat (3) @(posedge clk);
        #1;
        read_pair(5'd5, 5'd5, 64'h0, 64'h0, "we_low");
        do_write(5'd5, 64'hDEAD_BEEF_0123_4567);
        read_pair(5'd5, 5'd4, 64'hDEAD_BEEF_0123_4567, 64'h0, "we_high");
        check_all("after_reg5");

        // Zero register and full-width register 30
        do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        read_pair(5'd31, 5'd31, 64'h0, 64'h0, "zero_reg");
        do_write(5'd30, 64'hFFFF_FFFF_FFFF_FFFF);
        read_pair(5'd30, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, "reg30");

        // Read-during-write, both ports on the same register
        do_write(5'd7, 64'd1);
        rdAddrA = 5'd7;
        rdAddrB = 5'd7;
        @(negedge clk);
        write  = 1'b1;
        wrAddr = 5'd7;
        wrData = 64'd2;
        #1;
        chk("rdw_before_A", rdDataA, 64'd1);
        chk("rdw_before_B", rdDataB, 64'd1);
        @(posedge clk);
        #1;
        chk("rdw_after_A", rdDataA, 64'd2);
        chk("rdw_after_B", rdDataB, 64'd2);
        write    = 1'b0;
        model[7] = 64'd2;

        // Async reset pulse between edges while a write is pending
        @(negedge clk);
        write   = 1'b1;
        wrAddr  = 5'd9;
        wrData  = 64'h0000_0000_0000_0055;
        rdAddrA = 5'd0;
        rdAddrB = 5'd30;
        #1;
        chk("pre_async_A", rdDataA, 64'hFFFF);
        chk("pre_async_B", rdDataB, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        reset = 1'b1;
        #1;
        chk("async_A", rdDataA, 64'h0);
        chk("async_B", rdDataB, 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        write = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        #1;
        check_all("after_async");

        // Writes resume on the first edge after reset release
        do_write(5'd9, 64'h1234_5678_9ABC_DEF0);
        read_pair(5'd9, 5'd0, 64'h1234_5678_9ABC_DEF0, 64'h0, "resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_32x64.md
Name: regfile_32x64

Overview:
- 32-entry by 64-bit general-purpose register file for the datapath: two combinational read ports (A, B) and one clocked write port.
- Sits between instruction decode (read/write address selection) and the ALU/writeback path.
- Register 31 is the hardwired zero register (reads 0, writes discarded).

Parameters:
- DATA_WIDTH, 64, width of each register and of all data ports.
- ADDR_WIDTH, 5, address width; register count is 2**ADDR_WIDTH = 32.
- Only the defaults are required to be supported.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- rdAddrA  input  5  read port A register select.
- rdAddrB  input  5  read port B register select.
- rdDataA  output  64  contents of register rdAddrA.
- rdDataB  output  64  contents of register rdAddrB.
- wrAddr  input  5  write register select.
- wrData  input  64  write data.
- write  input  1  write enable, active-high, sampled on rising clk.

Behaviour:
- Storage: 32 registers of 64 bits (reg[0]..reg[31]).
- Reset:
  - When reset is asserted, all registers are cleared to 64'h0 immediately, with no clock edge required.
  - While reset is high, writes are blocked and both read ports return 0.
  - Reset has priority over a write on the same edge.
  - A write resumes on the first rising clk edge after reset deasserts.
- Write:
  - On a rising clk edge with reset=0 and write=1, reg[wrAddr] <= wrData.
  - With write=0, no register changes.
  - Only the addressed register is modified.
- Register 31:
  - Writes to address 31 are discarded.
  - Reads of address 31 always return 64'h0.
- Read:
  - Purely combinational, zero latency: rdDataA = reg[rdAddrA] and rdDataB = reg[rdAddrB].
  - Outputs follow address changes within the same cycle.
  - Both ports are independent and may address the same register simultaneously.
- Read-during-write:
  - There is no write-to-read bypass.
  - A read of wrAddr returns the old value until the rising edge commits the write, then the new value in the same cycle after the edge.
- No X propagation: all outputs are defined (0) from the first reset onward.
- Address inputs are fully decoded; there are no out-of-range addresses.

Test Plan:
- Reset: assert reset for 100 ns, then deassert -> rdDataA and rdDataB read 0 for every address 0..31.
- Basic write/read: write=1 with wrData=64'h0000_0000_0000_FFFF to addr 0, then 64'hAAAA to addr 1, 64'hCCCC to addr 2, 64'hF0F0 to addr 3, one clock each -> rdAddrA=0/rdAddrB=1 give FFFF/AAAA; rdAddrA=2/rdAddrB=3 give CCCC/F0F0.
- Write enable low: write=0, wrAddr=5, wrData=64'hDEAD_BEEF_0123_4567 across several edges -> reg5 still reads 0. Then set write=1 for one edge -> reg5 reads DEAD_BEEF_0123_4567, and every other register is unchanged.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to addr 31 -> rdDataA with rdAddrA=31 returns 0. Also write all-ones to addr 30 -> reads all-ones, confirming the full 64-bit width and that addr 30 is not affected by the addr-31 rule.
- Read-during-write and dual port: hold rdAddrA=rdAddrB=7 with reg7=1, write 2 to addr 7 -> both ports show 1 before the edge and 2 after the edge.
- Async reset mid-operation: with registers loaded, pulse reset high between clock edges while write=1 -> all reads drop to 0 immediately, before the next clk edge, and no write occurs while reset is high.
